// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port (CPU / ADC DMA) arbiter for one asynchronous 8-bit SRAM.
//   Each access runs setup / strobe / hold, and every SRAM-facing output comes from a register.
//   Optional macro SRAM_ARB_ROUND_ROBIN_EN: a tie goes to the port that lost the previous grant.
//   Without the macro the CPU always wins a tie.
//   Ports:
//     clk, reset                              system clock, synchronous active-high reset
//     cpu_req/we/addr/wdata -> rdata/ack      CPU requester (port 0)
//     dma_req/we/addr/wdata -> rdata/ack      ADC capture DMA requester (port 1)
//     sram_addr/dout/din/drive/ce_n/we_n/oe_n SRAM pins and pad-buffer controls
//     busy                                    high whenever the FSM is not in IDLE
module sram_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic [7:0]        dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dout,
    input  logic [7:0]        sram_din,
    output logic              sram_drive,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;
    state_t     state, state_n;
    logic [3:0] cnt;
    logic       lat_id, lat_we, any_req, win_dma, nxt_we;
    assign any_req = cpu_req | dma_req;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic prio_dma;
    assign win_dma = dma_req & (~cpu_req | prio_dma);
    always_ff @(posedge clk)
        if (reset)
            prio_dma <= 1'b0;
        else if (state == IDLE && any_req)
            prio_dma <= ~win_dma;
`else
    assign win_dma = dma_req & ~cpu_req;
`endif
    // Direction of the access about to run: live winner in IDLE, latched afterwards.
    assign nxt_we = (state == IDLE) ? (win_dma ? dma_we : cpu_we) : lat_we;
    assign busy   = state != IDLE;
    always_comb begin
        state_n = state;
        state_n = state == IDLE   ? (any_req ? SETUP : IDLE) :
                  state == SETUP  ? ACCESS :
                  state == ACCESS ? (cnt == 4'd0 ? HOLD : ACCESS) :
                  state == HOLD   ? DONE : IDLE;
    end
    always_ff @(posedge clk)
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    // Pin registers are loaded from the next state, so each strobe lines up with its FSM state.
    always_ff @(posedge clk)
        if (reset) begin
            cnt        <= 4'd0;
            lat_id     <= 1'b0;
            lat_we     <= 1'b0;
            sram_addr  <= '0;
            sram_dout  <= 8'd0;
            cpu_rdata  <= 8'd0;
            dma_rdata  <= 8'd0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_drive <= 1'b0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                lat_id    <= win_dma;
                lat_we    <= nxt_we;
                sram_addr <= win_dma ? dma_addr : cpu_addr;
                if (nxt_we)
                    sram_dout <= win_dma ? dma_wdata : cpu_wdata;
            end
            cnt <= (state == ACCESS) ? cnt - 4'd1 : 4'(WAIT_CYCLES - 1);
            if (state == ACCESS && cnt == 4'd0 && !lat_we) begin
                if (lat_id)
                    dma_rdata <= sram_din;
                else
                    cpu_rdata <= sram_din;
            end
            sram_ce_n  <= !(state_n inside {SETUP, ACCESS, HOLD});
            sram_oe_n  <= !(!nxt_we && state_n inside {SETUP, ACCESS});
            sram_we_n  <= !(nxt_we && state_n == ACCESS);
            sram_drive <= nxt_we && state_n inside {SETUP, ACCESS, HOLD};
            cpu_ack    <= state_n == DONE && !lat_id;
            dma_ack    <= state_n == DONE && lat_id;
        end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter at WAIT_CYCLES = 2, 1 and 15.
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req [3], cpu_we [3], dma_req [3], dma_we [3];
    logic [18:0] cpu_addr [3], dma_addr [3], sram_addr [3], pre_a [3];
    logic [7:0]  cpu_wdata [3], dma_wdata [3], cpu_rdata [3], dma_rdata [3];
    logic [7:0]  sram_dout [3], sram_din [3], pre_d [3], ovr [3];
    logic        cpu_ack [3], dma_ack [3], drive [3], ce_n [3], we_n [3], oe_n [3], busy [3];
    logic        pre_en [3], ovr_en [3];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : m
        localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        logic [7:0] mem [0:524287];
        sram_arbiter #(.ADDR_W(19), .WAIT_CYCLES(W)) dut (
            .clk(clk), .reset(reset),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]),
            .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]),
            .dma_wdata(dma_wdata[g]), .dma_rdata(dma_rdata[g]), .dma_ack(dma_ack[g]),
            .sram_addr(sram_addr[g]), .sram_dout(sram_dout[g]), .sram_din(sram_din[g]),
            .sram_drive(drive[g]), .sram_ce_n(ce_n[g]), .sram_we_n(we_n[g]),
            .sram_oe_n(oe_n[g]), .busy(busy[g])
        );
        always @(posedge clk)
            if (pre_en[g])
                mem[pre_a[g]] <= pre_d[g];
            else if (!ce_n[g] && !we_n[g])
                mem[sram_addr[g]] <= sram_dout[g];
        assign sram_din[g] = (!ce_n[g] && !oe_n[g]) ? (ovr_en[g] ? ovr[g] : mem[sram_addr[g]]) : 8'hFF;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int k, input logic [18:0] a, input logic [7:0] d);
        pre_a[k] = a;
        pre_d[k] = d;
        pre_en[k] = 1'b1;
        tick;
        pre_en[k] = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({ce_n[0], we_n[0], oe_n[0], drive[0], busy[0], cpu_ack[0], dma_ack[0]} !== 7'b1110000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1110000",
                     {ce_n[0], we_n[0], oe_n[0], drive[0], busy[0], cpu_ack[0], dma_ack[0]});
        end
        checks++;
        if ({sram_addr[0], sram_dout[0], cpu_rdata[0], dma_rdata[0]} !== 43'd0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h dout=%h crd=%h drd=%h expected all 0",
                     sram_addr[0], sram_dout[0], cpu_rdata[0], dma_rdata[0]);
        end
    endtask

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    task automatic test_round_robin;
        logic [3:0] order = 4'd0;
        int na = 0;
        cpu_addr[0] = 19'h123; cpu_we[0] = 1'b0; cpu_req[0] = 1'b1;
        dma_addr[0] = 19'h123; dma_we[0] = 1'b0; dma_req[0] = 1'b1;
        for (int n = 1; n <= 30 && na < 4; n++) begin
            tick;
            if (cpu_ack[0] === 1'b1 || dma_ack[0] === 1'b1) begin
                order[na] = dma_ack[0];
                na++;
                if (na == 4) begin cpu_req[0] = 1'b0; dma_req[0] = 1'b0; end
            end
        end
        checks++;
        if (na != 4 || order !== 4'b1010) begin
            errors++;
            $display("FAIL rr_order: got %0d grants order %b expected 4 grants order 1010", na, order);
        end
        tick; tick;
    endtask
`endif

    task automatic test_cpu_read;
        int ack_at = -1;
        bit bad = 1'b0;
        cpu_addr[0] = 19'h123; cpu_we[0] = 1'b0; cpu_req[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick;
            if (n == 1) begin
                checks++;
                if ({sram_addr[0], ce_n[0], oe_n[0], busy[0]} !== {19'h123, 1'b0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL cpu_read_setup: got addr=%h ce_n=%b oe_n=%b busy=%b expected 00123 0 0 1",
                             sram_addr[0], ce_n[0], oe_n[0], busy[0]);
                end
            end
            if (we_n[0] !== 1'b1 || drive[0] !== 1'b0) bad = 1'b1;
            if (cpu_ack[0] === 1'b1 && ack_at < 0) begin ack_at = n; cpu_req[0] = 1'b0; end
        end
        checks++;
        if (ack_at != 5) begin errors++; $display("FAIL cpu_read_ack: got cycle %0d expected 5", ack_at); end
        checks++;
        if (cpu_rdata[0] !== 8'hA5) begin errors++; $display("FAIL cpu_read_data: got %h expected a5", cpu_rdata[0]); end
        checks++;
        if (bad) begin errors++; $display("FAIL cpu_read_strobes: got we_n/drive active expected idle"); end
    endtask

    task automatic test_dma_write;
        logic [7:0] we_mask = 8'd0, dv_mask = 8'd0;
        int ack_at = -1;
        bit cack = 1'b0;
        dma_addr[0] = 19'h7FFFF; dma_we[0] = 1'b1; dma_wdata[0] = 8'h3C; dma_req[0] = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick;
            if (n == 1) begin
                checks++;
                if (sram_dout[0] !== 8'h3C) begin errors++; $display("FAIL dma_write_dout: got %h expected 3c", sram_dout[0]); end
            end
            we_mask[n] = !we_n[0];
            dv_mask[n] = drive[0];
            if (cpu_ack[0] !== 1'b0) cack = 1'b1;
            if (dma_ack[0] === 1'b1 && ack_at < 0) begin ack_at = n; dma_req[0] = 1'b0; dma_we[0] = 1'b0; end
        end
        checks++;
        if (we_mask !== 8'h0C) begin errors++; $display("FAIL dma_write_we: got %b expected 00001100", we_mask); end
        checks++;
        if (dv_mask !== 8'h1E) begin errors++; $display("FAIL dma_write_drive: got %b expected 00011110", dv_mask); end
        checks++;
        if (ack_at != 5 || cack) begin errors++; $display("FAIL dma_write_ack: got cycle %0d cpu_ack_seen=%b expected 5 0", ack_at, cack); end
        checks++;
        if (m[0].mem[19'h7FFFF] !== 8'h3C) begin errors++; $display("FAIL dma_write_mem: got %h expected 3c", m[0].mem[19'h7FFFF]); end
    endtask

    task automatic test_priority;
        int cat = -1, dat = -1;
        cpu_addr[0] = 19'h123; cpu_we[0] = 1'b0; cpu_req[0] = 1'b1;
        dma_addr[0] = 19'h7FFFF; dma_we[0] = 1'b0; dma_req[0] = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick;
            if (cpu_ack[0] === 1'b1 && cat < 0) begin cat = n; cpu_req[0] = 1'b0; end
            if (dma_ack[0] === 1'b1 && dat < 0) begin dat = n; dma_req[0] = 1'b0; end
        end
        checks++;
        if (cat != 5 || dat != 11) begin errors++; $display("FAIL priority_acks: got cpu %0d dma %0d expected 5 11", cat, dat); end
        checks++;
        if (cpu_rdata[0] !== 8'hA5 || dma_rdata[0] !== 8'h3C) begin
            errors++;
            $display("FAIL priority_data: got cpu %h dma %h expected a5 3c", cpu_rdata[0], dma_rdata[0]);
        end
    endtask

    task automatic test_reset_abort;
        int ack_at = -1;
        bit stray = 1'b0;
        cpu_addr[0] = 19'h200; cpu_we[0] = 1'b1; cpu_wdata[0] = 8'h55; cpu_req[0] = 1'b1;
        tick;
        tick;
        checks++;
        if (we_n[0] !== 1'b0) begin errors++; $display("FAIL abort_in_access: got we_n=%b expected 0", we_n[0]); end
        reset = 1'b1; cpu_req[0] = 1'b0; cpu_we[0] = 1'b0;
        tick;
        checks++;
        if ({we_n[0], ce_n[0], drive[0], busy[0], cpu_ack[0]} !== 5'b11000) begin
            errors++;
            $display("FAIL abort_state: got %b expected 11000", {we_n[0], ce_n[0], drive[0], busy[0], cpu_ack[0]});
        end
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick;
            if (cpu_ack[0] !== 1'b0 || dma_ack[0] !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin errors++; $display("FAIL abort_no_ack: got an ack expected none"); end
        cpu_addr[0] = 19'h123; cpu_req[0] = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick;
            if (cpu_ack[0] === 1'b1 && ack_at < 0) begin ack_at = n; cpu_req[0] = 1'b0; end
        end
        checks++;
        if (ack_at != 5 || cpu_rdata[0] !== 8'hA5) begin
            errors++;
            $display("FAIL abort_recover: got ack %0d data %h expected 5 a5", ack_at, cpu_rdata[0]);
        end
    endtask

    task automatic test_back_to_back;
        int acks [4] = '{-1, -1, -1, -1};
        logic [7:0] rd [4];
        logic [7:0] exp_rd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int exp_ack [4] = '{4, 9, 14, 19};
        int na = 0, dat = -1;
        bit rearm = 1'b0;
        cpu_addr[1] = 19'h10; cpu_we[1] = 1'b0; cpu_req[1] = 1'b1;
        dma_addr[1] = 19'h20; dma_we[1] = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        dma_req[1] = 1'b0;
`else
        dma_req[1] = 1'b1;
`endif
        for (int n = 1; n <= 30; n++) begin
            tick;
            if (rearm) begin cpu_req[1] = 1'b1; rearm = 1'b0; end
            if (cpu_ack[1] === 1'b1) begin
                if (na < 4) begin acks[na] = n; rd[na] = cpu_rdata[1]; end
                na++;
                cpu_req[1] = 1'b0;
                if (na < 4) begin cpu_addr[1] = 19'h10 + 19'(na); rearm = 1'b1; end
                else dma_req[1] = 1'b1;
            end
            if (dma_ack[1] === 1'b1 && dat < 0) begin dat = n; dma_req[1] = 1'b0; end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acks[i] != exp_ack[i] || rd[i] !== exp_rd[i]) begin
                errors++;
                $display("FAIL b2b_read%0d: got ack %0d data %h expected %0d %h", i, acks[i], rd[i], exp_ack[i], exp_rd[i]);
            end
        end
        checks++;
        if (na != 4 || dat != 24 || dma_rdata[1] !== 8'h99) begin
            errors++;
            $display("FAIL b2b_dma: got cpu acks %0d dma ack %0d data %h expected 4 24 99", na, dat, dma_rdata[1]);
        end
    endtask

    task automatic test_long_wait;
        int ack_at = -1;
        cpu_addr[2] = 19'h40; cpu_we[2] = 1'b0; cpu_req[2] = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            tick;
            if (n == 16) begin
                checks++;
                if (cpu_rdata[2] !== 8'h00) begin errors++; $display("FAIL long_early_capture: got %h expected 00", cpu_rdata[2]); end
                ovr[2] = 8'hC3; ovr_en[2] = 1'b1;
            end
            if (n == 17) ovr[2] = 8'h0F;
            if (cpu_ack[2] === 1'b1 && ack_at < 0) begin ack_at = n; cpu_req[2] = 1'b0; end
        end
        ovr_en[2] = 1'b0;
        checks++;
        if (ack_at != 18) begin errors++; $display("FAIL long_ack: got cycle %0d expected 18", ack_at); end
        checks++;
        if (cpu_rdata[2] !== 8'hC3) begin errors++; $display("FAIL long_data: got %h expected c3", cpu_rdata[2]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = 8'd0;
            dma_req[k] = 1'b0; dma_we[k] = 1'b0; dma_addr[k] = '0; dma_wdata[k] = 8'd0;
            pre_en[k] = 1'b0; pre_a[k] = '0; pre_d[k] = 8'd0; ovr_en[k] = 1'b0; ovr[k] = 8'd0;
        end
        poke(0, 19'h123, 8'hA5);
        poke(1, 19'h10, 8'h11);
        poke(1, 19'h11, 8'h22);
        poke(1, 19'h12, 8'h33);
        poke(1, 19'h13, 8'h44);
        poke(1, 19'h20, 8'h99);
        poke(2, 19'h40, 8'h5A);
        tick;
        test_reset;
        reset = 1'b0;
        tick;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        test_round_robin;
`endif
        test_cpu_read;
        test_dma_write;
        test_priority;
        test_reset_abort;
        test_back_to_back;
        test_long_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
